// File: rtl/vga_pkg.sv
// Shared constants, control bytes, state type and cell address helper for
// the 40x30 text console.
package vga_pkg;

  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned CELLS = 1200;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  // row*40+col using shifts (row*32 + row*8 + col); max 1199 fits 11 bits
  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    logic [10:0] r;
    r = {6'b0, row};
    return (r << 5) + (r << 3) + {5'b0, col};
  endfunction

endpackage

// File: rtl/vga_console_if.sv
// Producer-to-console byte stream handshake.
interface vga_console_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/vga_clear_seq.sv
// Address generator for the clear sequences: emits base..base+count-1, one
// address per cycle, starting the cycle after start.  done is high once the
// last address has been emitted.  Out of reset it is preloaded with a full
// screen clear so the console fills the screen immediately after release.
module vga_clear_seq
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] base,
  input  logic [10:0] count,
  output logic [10:0] addr,
  output logic        done
);

  logic [10:0] base_r;
  logic [10:0] len_r;
  logic [10:0] idx;
  logic        active;

  // load on start, otherwise step once per cycle until the last address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_r <= '0;
      len_r  <= 11'(CELLS);
      idx    <= '0;
      active <= 1'b1;
    end else if (start) begin
      base_r <= base;
      len_r  <= count;
      idx    <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (idx == len_r - 11'd1) begin
        active <= 1'b0;
      end
      idx <= idx + 11'd1;
    end
  end

  assign addr = base_r + idx;
  assign done = ~active;

endmodule

// File: rtl/vga_console.sv
// Byte-stream text console writing a 40x30 character VRAM.
// Optional feature: define VGA_CONSOLE_BS_EN to make 0x08 a destructive
// backspace; otherwise 0x08 is printed like any other byte.
module vga_console
  import vga_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  vga_console_if.slave       in_if,
  output logic [10:0]        vram_waddr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic [5:0]         cur_col,
  output logic [4:0]         cur_row,
  output logic               busy
);

  state_t      state;
  state_t      state_n;
  logic        accept;
  logic        is_bs;
  logic [4:0]  row_inc;
  logic [5:0]  col_n;
  logic [4:0]  row_n;
  logic        we_n;
  logic [10:0] waddr_n;
  logic [7:0]  wdata_n;
  logic        seq_start;
  logic [10:0] seq_base;
  logic [10:0] seq_count;
  logic [10:0] seq_addr;
  logic        seq_done;

  assign accept  = in_if.in_valid & in_if.in_ready;
  assign row_inc = (cur_row == 5'(ROWS - 1)) ? '0 : cur_row + 5'd1;

`ifdef VGA_CONSOLE_BS_EN
  assign is_bs = (in_if.in_data == CH_BS);
`else
  assign is_bs = 1'b0;
`endif

  vga_clear_seq u_clear_seq (
    .clk   (clk),
    .reset (reset),
    .start (seq_start),
    .base  (seq_base),
    .count (seq_count),
    .addr  (seq_addr),
    .done  (seq_done)
  );

  // Next-state, cursor and write decode.  Clear states spend one extra cycle
  // after the last write so in_ready only rises once all clear writes are out.
  always_comb begin
    state_n   = state;
    col_n     = cur_col;
    row_n     = cur_row;
    we_n      = 1'b0;
    waddr_n   = vram_waddr;
    wdata_n   = vram_wdata;
    seq_start = 1'b0;
    seq_base  = '0;
    seq_count = 11'(COLS);
    case (state)
      CLR_ALL, CLR_ROW: begin
        if (!seq_done) begin
          we_n    = 1'b1;
          waddr_n = seq_addr;
          wdata_n = CLEAR_CHAR;
        end else begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          if (in_if.in_data == CH_CR) begin
            col_n = '0;
          end else if (in_if.in_data == CH_LF) begin
            col_n     = '0;
            row_n     = row_inc;
            seq_start = 1'b1;
            seq_base  = cell_addr(row_inc, 6'd0);
            state_n   = CLR_ROW;
          end else if (in_if.in_data == CH_FF) begin
            col_n     = '0;
            row_n     = '0;
            seq_start = 1'b1;
            seq_count = 11'(CELLS);
            state_n   = CLR_ALL;
          end else if (is_bs) begin
            col_n   = (cur_col == 6'd0) ? 6'd0 : cur_col - 6'd1;
            we_n    = 1'b1;
            waddr_n = cell_addr(cur_row, col_n);
            wdata_n = CLEAR_CHAR;
          end else begin
            we_n    = 1'b1;
            waddr_n = cell_addr(cur_row, cur_col);
            wdata_n = in_if.in_data;
            if (cur_col == 6'(COLS - 1)) begin
              col_n     = '0;
              row_n     = row_inc;
              seq_start = 1'b1;
              seq_base  = cell_addr(row_inc, 6'd0);
              state_n   = CLR_ROW;
            end else begin
              col_n = cur_col + 6'd1;
            end
          end
        end
      end
      default: state_n = CLR_ALL;
    endcase
  end

  // Registered state and outputs; ready/busy are decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLR_ALL;
      cur_col     <= '0;
      cur_row     <= '0;
      vram_we     <= 1'b0;
      vram_waddr  <= '0;
      vram_wdata  <= '0;
      in_if.in_ready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cur_col     <= col_n;
      cur_row     <= row_n;
      vram_we     <= we_n;
      vram_waddr  <= waddr_n;
      vram_wdata  <= wdata_n;
      in_if.in_ready <= (state_n == IDLE);
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_vga_console.sv
// Self-checking bench for vga_console: a screen-level model predicts the
// list of VRAM writes and the final cursor for each byte sent.
module tb_vga_console;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  vga_console_if bus ();

  vga_console #(.CLEAR_CHAR(8'h20)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int mc = 0;
  int mr = 0;
  int first_we;
  logic first_busy;
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_row();
    for (int i = 0; i < 40; i++) exp_q.push_back({11'(mr * 40 + i), 8'h20});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h0A) begin
      mc = 0; mr = (mr + 1) % 30; model_row();
    end else if (b == 8'h0C) begin
      mc = 0; mr = 0;
      for (int i = 0; i < 1200; i++) exp_q.push_back({11'(i), 8'h20});
`ifdef VGA_CONSOLE_BS_EN
    end else if (b == 8'h08) begin
      if (mc > 0) mc--;
      exp_q.push_back({11'(mr * 40 + mc), 8'h20});
`endif
    end else begin
      exp_q.push_back({11'(mr * 40 + mc), b});
      mc++;
      if (mc == 40) begin
        mc = 0; mr = (mr + 1) % 30; model_row();
      end
    end
  endtask

  // gather writes until in_ready returns, then compare with the model
  task automatic collect(input string tag);
    int n = 0;
    int bad = -1;
    int lim;
    bit done = 0;
    logic [10:0] maxa = '0;
    got_q.delete();
    first_we = -1;
    while (!done && n < 1400) begin
      @(negedge clk);
      n++;
      if (n == 1) first_busy = busy;
      if (vram_we) begin
        if (first_we < 0) first_we = n;
        got_q.push_back({vram_waddr, vram_wdata});
        if (vram_waddr > maxa) maxa = vram_waddr;
      end
      if (bus.in_ready) done = 1;
    end
    check({tag, "_ready_timeout"}, 32'(done), 32'd1);
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    check({tag, "_first_bad_write"}, 32'(bad), 32'hffff_ffff);
    check({tag, "_addr_le_1199"}, 32'(maxa <= 11'd1199), 32'd1);
    check({tag, "_col"}, 32'(cur_col), 32'(mc));
    check({tag, "_row"}, 32'(cur_row), 32'(mr));
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    int w = 0;
    while (!bus.in_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check({tag, "_wait_ready"}, 32'd0, 32'd1);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_byte(b);
    collect(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(vram_we),    32'd0);
    check({tag, "_waddr"}, 32'(vram_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(vram_wdata), 32'd0);
    check({tag, "_col"},   32'(cur_col),    32'd0);
    check({tag, "_row"},   32'(cur_row),    32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  initial begin
    int k, t, bad;
    logic [7:0] b;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // power-up full clear
    reset = 1'b0;
    for (int i = 0; i < 1200; i++) exp_q.push_back({11'(i), 8'h20});
    collect("init_clear");
    check("init_busy", 32'(first_busy), 32'd1);

    // single character at home, one-cycle latency
    send(8'h41, "char_A");
    check("char_A_latency", 32'(first_we), 32'd1);

    // move to (39,2) then wrap with 'Z'
    send(8'h0D, "cr");
    send(8'h0A, "lf1");
    send(8'h0A, "lf2");
    for (int i = 0; i < 39; i++) send(8'($urandom_range(32, 126)), "fill_row2");
    send(8'h5A, "wrap_Z");
    check("wrap_Z_latency", 32'(first_we), 32'd1);

    // advance to last row then wrap to top
    while (mr != 29) send(8'h0A, "lf_walk");
    send(8'h0A, "lf_wrap_top");

`ifdef VGA_CONSOLE_BS_EN
    send(8'h0A, "bs_lf");
    for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)), "bs_fill");
    send(8'h08, "bs_mid");
    send(8'h0D, "bs_cr");
    send(8'h08, "bs_col0");
`else
    send(8'h08, "bs_as_char");
`endif

    // randomized mix of printable, CR and LF
    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) b = 8'h0D;
      else if (k == 1) b = 8'h0A;
      else b = 8'($urandom_range(32, 126));
      send(b, "random");
    end

    // form feed from mid-screen, reset at clear write 500
    send(8'h0A, "pre_ff_lf");
    send(8'h42, "pre_ff_char");
    bus.in_data  = 8'h0C;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_byte(8'h0C);
    @(negedge clk);
    check("ff_home_col", 32'(cur_col), 32'd0);
    check("ff_home_row", 32'(cur_row), 32'd0);
    check("ff_busy", 32'(busy), 32'd1);
    check("ff_nowrite", 32'(vram_we), 32'd0);
    k = 0; t = 0; bad = 0;
    while (k < 500 && t < 2000) begin
      @(negedge clk);
      t++;
      if (vram_we) begin
        if ({vram_waddr, vram_wdata} !== exp_q[k]) bad++;
        k++;
      end
    end
    check("ff_500_writes", 32'(k), 32'd500);
    check("ff_500_bad", 32'(bad), 32'd0);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mc = 0; mr = 0;
    for (int i = 0; i < 1200; i++) exp_q.push_back({11'(i), 8'h20});
    collect("restart_clear");
    send(8'h43, "post_restart_char");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
